// File: rtl/parse_pkg.sv
// -----------------------------------------------------------------------------
// parse_pkg
// Shared defaults for the instruction parse queue and the layer control FSM:
// field widths, queue depth, the number of legal opcodes and the opcode
// enumeration. Both blocks import this package so that they agree on the
// meaning of every opcode value.
// -----------------------------------------------------------------------------
package parse_pkg;

    // Default field widths of a packed instruction code {op, a, b}
    localparam int OP_SIZE_D      = 4;
    localparam int PARAM_A_SIZE_D = 4;
    localparam int PARAM_B_SIZE_D = 4;

    // Default queue depth (power of two) and count of legal opcodes
    localparam int DEPTH_D   = 4;
    localparam int NUM_OPS_D = 8;

    // Opcode enumeration shared with the layer control FSM
    localparam logic [OP_SIZE_D-1:0] OP_NOP   = 4'd0;
    localparam logic [OP_SIZE_D-1:0] OP_LOAD  = 4'd1;
    localparam logic [OP_SIZE_D-1:0] OP_STORE = 4'd2;
    localparam logic [OP_SIZE_D-1:0] OP_DENSE = 4'd3;
    localparam logic [OP_SIZE_D-1:0] OP_ACT   = 4'd4;
    localparam logic [OP_SIZE_D-1:0] OP_POOL  = 4'd5;
    localparam logic [OP_SIZE_D-1:0] OP_COST  = 4'd6;
    localparam logic [OP_SIZE_D-1:0] OP_HALT  = 4'd7;

endpackage

// File: rtl/code_fifo.sv
// -----------------------------------------------------------------------------
// code_fifo
// Synchronous FIFO holding packed instruction codes.
// Pointers are $clog2(DEPTH) bits and wrap naturally (DEPTH is a power of
// two); a separate level counter one bit wider tells full from empty.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   flush            empties the FIFO at the edge; a push in that cycle is lost
//   push, wdata      write request and data (ignored when full)
//   pop              read request (ignored when empty)
//   rdata            head entry (valid when !empty)
//   level            number of stored entries
//   full, empty      occupancy flags derived from level
// -----------------------------------------------------------------------------
module code_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == FULL_LVL);
    assign empty     = (level_r == '0);
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_push_s = push && !full && !flush && !reset;
    assign do_pop_s  = pop && !empty && !flush && !reset;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/parse_queue.sv
// -----------------------------------------------------------------------------
// parse_queue
// Buffers packed instruction codes from the sequencer in a DEPTH-entry FIFO
// and presents the head, split into its fields, from a registered output stage
// to the datapath controller. The queue is never bypassed, so a code pushed at
// one edge is presented after the following edge at the earliest.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   flush                 drops the queue contents and the output stage
//   in_code/in_valid/in_ready   push handshake ({op, a, b})
//   op/act_type/dense_type/cost_type   decoded fields of the presented code
//   op_onehot             bit[op] set for a legal opcode, zero otherwise
//   illegal               presented opcode is >= NUM_OPS
//   out_valid/out_ready   output handshake
//   level                 FIFO occupancy, excluding the output stage
//   err_sticky            an illegal opcode was presented since reset/flush
// -----------------------------------------------------------------------------
module parse_queue
    import parse_pkg::*;
#(
    parameter int OP_SIZE      = OP_SIZE_D,
    parameter int PARAM_A_SIZE = PARAM_A_SIZE_D,
    parameter int PARAM_B_SIZE = PARAM_B_SIZE_D,
    parameter int DEPTH        = DEPTH_D,
    parameter int NUM_OPS      = NUM_OPS_D,
    localparam int CW   = OP_SIZE + PARAM_A_SIZE + PARAM_B_SIZE,
    localparam int AB   = PARAM_A_SIZE + PARAM_B_SIZE,
    localparam int LW   = $clog2(DEPTH) + 1,
    localparam int OH_W = 2 ** OP_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [CW-1:0]           in_code,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OP_SIZE-1:0]      op,
    output logic [PARAM_A_SIZE-1:0] act_type,
    output logic [PARAM_B_SIZE-1:0] dense_type,
    output logic [AB-1:0]           cost_type,
    output logic [OH_W-1:0]         op_onehot,
    output logic                    illegal,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LW-1:0]           level,
    output logic                    err_sticky
);

    // One extra bit so NUM_OPS == 2**OP_SIZE is representable
    localparam logic [OP_SIZE:0] NUM_OPS_L = (OP_SIZE + 1)'(NUM_OPS);

    logic [CW-1:0]           head_code_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic                    push_s;
    logic                    load_s;
    logic [OP_SIZE-1:0]      head_op_s;
    logic [PARAM_A_SIZE-1:0] head_a_s;
    logic [PARAM_B_SIZE-1:0] head_b_s;
    logic                    head_illegal_s;
    logic [OH_W-1:0]         head_onehot_s;

    logic [OP_SIZE-1:0]      op_r;
    logic [PARAM_A_SIZE-1:0] act_type_r;
    logic [PARAM_B_SIZE-1:0] dense_type_r;
    logic [AB-1:0]           cost_type_r;
    logic [OH_W-1:0]         op_onehot_r;
    logic                    illegal_r;
    logic                    out_valid_r;
    logic                    err_sticky_r;

    // in_ready depends only on stored occupancy, never on out_ready
    assign in_ready = !fifo_full_s;
    assign push_s   = in_valid && !fifo_full_s;
    // Refill the output stage whenever it is empty or being consumed
    assign load_s   = !fifo_empty_s && (!out_valid_r || out_ready) && !flush;

    code_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_code_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push_s),
        .wdata (in_code),
        .pop   (load_s),
        .rdata (head_code_s),
        .level (level),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign head_op_s = head_code_s[CW-1 -: OP_SIZE];
    assign head_a_s  = head_code_s[AB-1 -: PARAM_A_SIZE];
    assign head_b_s  = head_code_s[PARAM_B_SIZE-1:0];

    // Legality check and one-hot opcode of the FIFO head
    always_comb begin
        head_illegal_s = ({1'b0, head_op_s} >= NUM_OPS_L);
        head_onehot_s  = '0;
        if (!head_illegal_s) begin
            head_onehot_s[head_op_s] = 1'b1;
        end else begin
            head_onehot_s = '0;
        end
    end

    // Output stage: loads from the head, holds fields while not refilled
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r         <= '0;
            act_type_r   <= '0;
            dense_type_r <= '0;
            cost_type_r  <= '0;
            op_onehot_r  <= '0;
            illegal_r    <= 1'b0;
            out_valid_r  <= 1'b0;
            err_sticky_r <= 1'b0;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            err_sticky_r <= 1'b0;
        end else if (load_s) begin
            op_r         <= head_op_s;
            act_type_r   <= head_a_s;
            dense_type_r <= head_b_s;
            cost_type_r  <= head_code_s[AB-1:0];
            op_onehot_r  <= head_onehot_s;
            illegal_r    <= head_illegal_s;
            out_valid_r  <= 1'b1;
            err_sticky_r <= err_sticky_r || head_illegal_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r  <= 1'b0;
        end
    end

    assign op         = op_r;
    assign act_type   = act_type_r;
    assign dense_type = dense_type_r;
    assign cost_type  = cost_type_r;
    assign op_onehot  = op_onehot_r;
    assign illegal    = illegal_r;
    assign out_valid  = out_valid_r;
    assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_parse_queue.sv
// -----------------------------------------------------------------------------
// tb_parse_queue
// Scoreboard bench for parse_queue (default parameters). Accepted codes are
// queued; a monitor on the falling edge compares every presented output with
// the oldest outstanding code, decoded arithmetically, and also checks level,
// in_ready and err_sticky against the scoreboard state.
// -----------------------------------------------------------------------------
module tb_parse_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [11:0] in_code;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [3:0]  act_type;
    logic [3:0]  dense_type;
    logic [7:0]  cost_type;
    logic [15:0] op_onehot;
    logic        illegal;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        err_sticky;

    int checks = 0;
    int errors = 0;

    logic [11:0] sb[$];
    logic        exp_sticky = 1'b0;
    logic        started = 1'b0;

    parse_queue dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .act_type   (act_type),
        .dense_type (dense_type),
        .cost_type  (cost_type),
        .op_onehot  (op_onehot),
        .illegal    (illegal),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare presented output with the oldest outstanding code,
    // then apply what the coming edge does to the scoreboard.
    always @(negedge clk) begin
        int c, e_op, e_act, e_dense, e_cost, e_oh, e_lvl;
        bit e_ill;
        if (started) begin
            e_lvl = sb.size() - (out_valid ? 1 : 0);
            chk("level", 32'(level), e_lvl);
            chk("in_ready", 32'(in_ready), (e_lvl != 4) ? 1 : 0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    c       = int'(sb[0]);
                    e_op    = c / 256;
                    e_act   = (c / 16) % 16;
                    e_dense = c % 16;
                    e_cost  = c % 256;
                    e_ill   = (e_op >= 8);
                    e_oh    = e_ill ? 0 : (1 << e_op);
                    chk("op", 32'(op), e_op);
                    chk("act_type", 32'(act_type), e_act);
                    chk("dense_type", 32'(dense_type), e_dense);
                    chk("cost_type", 32'(cost_type), e_cost);
                    chk("op_onehot", 32'(op_onehot), e_oh);
                    chk("illegal", 32'(illegal), 32'(e_ill));
                    if (e_ill) exp_sticky = 1'b1;
                end
            end
            chk("err_sticky", 32'(err_sticky), 32'(exp_sticky));
        end
        if (reset) begin
            sb.delete();
            exp_sticky = 1'b0;
            started    = 1'b1;
        end else if (flush) begin
            sb.delete();
            exp_sticky = 1'b0;
        end else begin
            if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
            if (in_valid && in_ready) sb.push_back(in_code);
        end
    end

    // Holds in_valid with code c until an edge accepts it
    task automatic push_code(input logic [11:0] c);
        logic acc;
        int   n;
        in_code  = c;
        in_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_code = 12'h000; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_cost", 32'(cost_type), 32'd0);
        chk("rst_onehot", 32'(op_onehot), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // 1: single code, latency of one extra edge
        in_code = 12'h3A5; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_op", 32'(op), 32'd3);
        chk("t1_act", 32'(act_type), 32'hA);
        chk("t1_dense", 32'(dense_type), 32'd5);
        chk("t1_cost", 32'(cost_type), 32'hA5);
        chk("t1_onehot", 32'(op_onehot), 32'h0008);
        chk("t1_illegal", 32'(illegal), 32'd0);
        wait_drain();

        // 2: fill queue plus output stage with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_code(12'($urandom_range(0, 4095)));
        in_code = 12'h6C3;
        @(negedge clk);
        chk("t2_level_full", 32'(level), 32'd4);
        chk("t2_in_ready_low", 32'(in_ready), 32'd0);
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        push_code(12'h6C3);
        wait_drain();

        // 3: illegal opcode sets sticky error, legal one keeps it
        push_code(12'h9A5);
        in_valid = 1'b0;
        wait_valid();
        chk("t3_illegal", 32'(illegal), 32'd1);
        chk("t3_onehot", 32'(op_onehot), 32'd0);
        chk("t3_sticky", 32'(err_sticky), 32'd1);
        push_code(12'h1FF);
        wait_drain();
        chk("t3_illegal_clr", 32'(illegal), 32'd0);
        chk("t3_onehot_1", 32'(op_onehot), 32'h0002);
        chk("t3_sticky_held", 32'(err_sticky), 32'd1);

        // 4: steady one-in one-out with two entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_code(12'($urandom_range(0, 4095)));
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_level2", 32'(level), 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_code  = 12'($urandom_range(0, 4095));
            in_valid = 1'b1;
            @(negedge clk);
            chk("t4_level_steady", 32'(level), 32'd2);
            @(posedge clk); #1;
        end
        wait_drain();

        // 5: flush with a full queue and a push in the same cycle
        out_ready = 1'b0;
        push_code(12'hF00);
        for (int i = 0; i < 4; i++) push_code(12'($urandom_range(0, 2047)));
        in_code = 12'h7EE; in_valid = 1'b1;
        @(negedge clk);
        chk("t5_sticky_before", 32'(err_sticky), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_sticky", 32'(err_sticky), 32'd0);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("t5_nothing_out", 32'(out_valid), 32'd0);

        // 6: reset while an output is presented
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_code(12'($urandom_range(1, 4095)));
        in_valid = 1'b0;
        wait_valid();
        reset = 1'b1; in_code = 12'h123; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_op", 32'(op), 32'd0);
        chk("t6_cost", 32'(cost_type), 32'd0);
        chk("t6_onehot", 32'(op_onehot), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_sticky", 32'(err_sticky), 32'd0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_code   = 12'($urandom_range(0, 4095));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
